// File: rtl/uart_cmd_seq_if.sv
// Bundle of signals between the UART receiver, the command sequencer and the
// robot command decoder.
//   rx_rdy/rx_byte/clr_rdy : receiver byte handshake (rdy held until cleared)
//   cmd_vld/opcode/data/cmd_ack : frame handed downstream, held until acked
//   frm_err : one-cycle pulse per dropped frame
//   busy    : sequencer is inside a frame or holding one
// Handshakes: a byte is consumed when rx_rdy=1 and the sequencer is not already
// pulsing clr_rdy; a frame is consumed on the cycle cmd_vld=1 and cmd_ack=1.
// master = sequencer view, slave = surrounding receiver/decoder view.
interface uart_cmd_seq_if;
    logic       rx_rdy;
    logic [7:0] rx_byte;
    logic       clr_rdy;
    logic       cmd_vld;
    logic [7:0] opcode;
    logic [7:0] data;
    logic       cmd_ack;
    logic       frm_err;
    logic       busy;

    modport master (
        input  rx_rdy, rx_byte, cmd_ack,
        output clr_rdy, cmd_vld, opcode, data, frm_err, busy
    );

    modport slave (
        output rx_rdy, rx_byte, cmd_ack,
        input  clr_rdy, cmd_vld, opcode, data, frm_err, busy
    );
endinterface

// File: rtl/uart_cmd_seq.sv
// Command sequencer: frames received UART bytes as SYNC, OPCODE, DATA and hands
// each complete frame to the command decoder.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : uart_cmd_seq_if.master (receiver and decoder handshakes)
//   state_dbg  : current FSM state (0 IDLE, 1 GET_OP, 2 GET_DATA, 3 HOLD)
// Valid/ready rules: a byte is taken when rx_rdy=1, clr_rdy=0 and the FSM is
// not in HOLD; clr_rdy pulses for one cycle after each take. A frame is handed
// over while cmd_vld=1 and is retired on the edge where cmd_ack=1.
module uart_cmd_seq #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd52083
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_cmd_seq_if.master        bus,
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_OP   = 2'd1,
        GET_DATA = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = TIMEOUT - 16'd1;

    state_t      state_q, state_n;
    logic [15:0] cnt_q, cnt_n;
    logic [7:0]  opcode_q, opcode_n;
    logic [7:0]  data_q, data_n;
    logic        vld_q, vld_n;
    logic        clr_q, clr_n;
    logic        err_q, err_n;
    logic        take;

    // The receiver drops rx_rdy one cycle after clr_rdy, so rx_rdy is still
    // high while clr_rdy is; masking with clr_q prevents a second capture.
    // In HOLD incoming bytes stay pending in the receiver.
    assign take = bus.rx_rdy & ~clr_q & (state_q != HOLD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opcode_q <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            clr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            opcode_q <= opcode_n;
            data_q   <= data_n;
            vld_q    <= vld_n;
            clr_q    <= clr_n;
            err_q    <= err_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        opcode_n = opcode_q;
        data_n   = data_q;
        vld_n    = vld_q;
        clr_n    = take;
        err_n    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                // Non-sync bytes are consumed silently (line noise).
                if (take && bus.rx_byte == SYNC_BYTE) begin
                    state_n = GET_OP;
                end
            end
            GET_OP: begin
                if (take) begin
                    opcode_n = bus.rx_byte;
                    cnt_n    = '0;
                    state_n  = GET_DATA;
                end else if (cnt_q == TO_LAST) begin
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            GET_DATA: begin
                if (take) begin
                    data_n  = bus.rx_byte;
                    vld_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = HOLD;
                end else if (cnt_q == TO_LAST) begin
                    err_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                cnt_n = '0;
                if (bus.cmd_ack) begin
                    vld_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                vld_n   = 1'b0;
            end
        endcase
    end

    assign bus.clr_rdy = clr_q;
    assign bus.cmd_vld = vld_q;
    assign bus.opcode  = opcode_q;
    assign bus.data    = data_q;
    assign bus.frm_err = err_q;
    assign bus.busy    = (state_q != IDLE);
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed bench for uart_cmd_seq with a short frame timeout.
module tb_uart_cmd_seq;
    localparam logic [15:0] TO = 16'd20;

    logic        clk;
    logic        rst_n;
    logic [1:0]  state_dbg;
    int          checks;
    int          errors;
    int          cyc;
    int          clr_cnt;
    int          err_cnt;

    uart_cmd_seq_if bus ();

    uart_cmd_seq #(.SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.clr_rdy) clr_cnt <= clr_cnt + 1;
        if (bus.frm_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver model: present a byte, keep rdy high through the clr_rdy cycle,
    // then drop it. Reports cmd_vld/busy as seen in the clr_rdy cycle.
    task automatic send_byte(input logic [7:0] b, output logic vld_at_clr,
                             output logic busy_at_clr);
        logic seen;
        seen = 1'b0;
        vld_at_clr = 1'b0;
        busy_at_clr = 1'b0;
        @(negedge clk);
        bus.rx_byte = b;
        bus.rx_rdy  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.clr_rdy) begin
                seen = 1'b1;
                vld_at_clr = bus.cmd_vld;
                busy_at_clr = bus.busy;
                break;
            end
        end
        check("clr_seen", {15'd0, seen}, 16'd1);
        @(negedge clk);
        check("clr_width", {15'd0, bus.clr_rdy}, 16'd0);
        bus.rx_rdy = 1'b0;
    endtask

    task automatic ack_frame();
        @(negedge clk);
        bus.cmd_ack = 1'b1;
        @(negedge clk);
        bus.cmd_ack = 1'b0;
        check("ack_vld_low", {15'd0, bus.cmd_vld}, 16'd0);
        check("ack_idle", {14'd0, state_dbg}, 16'd0);
    endtask

    initial begin
        logic v, bz;
        int c0, e0, t_take, held;
        logic got_err;
        checks = 0; errors = 0; cyc = 0; clr_cnt = 0; err_cnt = 0;
        rst_n = 1'b0;
        bus.rx_rdy = 1'b0; bus.rx_byte = 8'h00; bus.cmd_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_clr", {15'd0, bus.clr_rdy}, 16'd0);
        check("rst_vld", {15'd0, bus.cmd_vld}, 16'd0);
        check("rst_op", {8'd0, bus.opcode}, 16'd0);
        check("rst_data", {8'd0, bus.data}, 16'd0);
        check("rst_err", {15'd0, bus.frm_err}, 16'd0);
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        rst_n = 1'b1;

        // Frame A5,12,34, held without ack for 100 cycles
        @(negedge clk);
        c0 = clr_cnt;
        send_byte(8'hA5, v, bz);
        check("f1_b0_vld", {15'd0, v}, 16'd0);
        send_byte(8'h12, v, bz);
        check("f1_b1_vld", {15'd0, v}, 16'd0);
        send_byte(8'h34, v, bz);
        check("f1_vld_latency", {15'd0, v}, 16'd1);
        check("f1_clr_count", 16'(clr_cnt - c0), 16'd3);
        check("f1_op", {8'd0, bus.opcode}, 16'h12);
        check("f1_data", {8'd0, bus.data}, 16'h34);
        held = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cmd_vld && bus.opcode == 8'h12 && bus.data == 8'h34) held++;
        end
        check("f1_hold", 16'(held), 16'd100);
        check("f1_hold_state", {14'd0, state_dbg}, 16'd3);
        ack_frame();
        check("f1_busy_after", {15'd0, bus.busy}, 16'd0);

        // cmd_ack in IDLE is ignored
        @(negedge clk);
        bus.cmd_ack = 1'b1;
        @(negedge clk);
        bus.cmd_ack = 1'b0;
        check("ack_idle_ign", {15'd0, bus.busy}, 16'd0);

        // Noise bytes 00,FF then frame A5,01,02
        c0 = clr_cnt; e0 = err_cnt;
        send_byte(8'h00, v, bz);
        check("noise0_vld", {15'd0, v}, 16'd0);
        check("noise0_busy", {15'd0, bz}, 16'd0);
        send_byte(8'hFF, v, bz);
        check("noise1_vld", {15'd0, v}, 16'd0);
        check("noise_clr", 16'(clr_cnt - c0), 16'd2);
        check("noise_err", 16'(err_cnt - e0), 16'd0);
        send_byte(8'hA5, v, bz);
        send_byte(8'h01, v, bz);
        send_byte(8'h02, v, bz);
        check("f2_vld", {15'd0, bus.cmd_vld}, 16'd1);
        check("f2_op", {8'd0, bus.opcode}, 16'h01);
        check("f2_data", {8'd0, bus.data}, 16'h02);
        ack_frame();

        // Timeout: A5,07 then silence
        send_byte(8'hA5, v, bz);
        send_byte(8'h07, v, bz);
        t_take = cyc - 1;
        got_err = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.frm_err) begin
                got_err = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("to_seen", {15'd0, got_err}, 16'd1);
        check("to_latency", 16'(cyc - t_take), TO);
        check("to_no_vld", {15'd0, bus.cmd_vld}, 16'd0);
        @(negedge clk);
        check("to_pulse_width", {15'd0, bus.frm_err}, 16'd0);
        check("to_busy", {15'd0, bus.busy}, 16'd0);
        send_byte(8'hA5, v, bz);
        send_byte(8'h03, v, bz);
        send_byte(8'h04, v, bz);
        check("f3_op", {8'd0, bus.opcode}, 16'h03);
        check("f3_data", {8'd0, bus.data}, 16'h04);
        ack_frame();

        // Take guard: a single byte held across its clr cycle is taken once
        c0 = clr_cnt;
        send_byte(8'h3C, v, bz);
        repeat (3) @(negedge clk);
        check("guard_once", 16'(clr_cnt - c0), 16'd1);

        // Byte arriving during HOLD stays pending until the ack
        send_byte(8'hA5, v, bz);
        send_byte(8'h10, v, bz);
        send_byte(8'h20, v, bz);
        c0 = clr_cnt;
        @(negedge clk);
        bus.rx_byte = 8'hA5;
        bus.rx_rdy  = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_no_clr", 16'(clr_cnt - c0), 16'd0);
        check("hold_vld", {15'd0, bus.cmd_vld}, 16'd1);
        check("hold_op", {8'd0, bus.opcode}, 16'h10);
        bus.cmd_ack = 1'b1;
        @(negedge clk);
        bus.cmd_ack = 1'b0;
        check("hold_ack_vld", {15'd0, bus.cmd_vld}, 16'd0);
        check("hold_ack_clr", {15'd0, bus.clr_rdy}, 16'd0);
        @(negedge clk);
        check("pend_clr", {15'd0, bus.clr_rdy}, 16'd1);
        check("pend_busy", {15'd0, bus.busy}, 16'd1);
        check("pend_state", {14'd0, state_dbg}, 16'd1);
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        send_byte(8'h11, v, bz);
        send_byte(8'h22, v, bz);
        check("f4_op", {8'd0, bus.opcode}, 16'h11);
        check("f4_data", {8'd0, bus.data}, 16'h22);
        ack_frame();

        // Reset mid-frame
        send_byte(8'hA5, v, bz);
        send_byte(8'h55, v, bz);
        check("mid_op", {8'd0, bus.opcode}, 16'h55);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_vld", {15'd0, bus.cmd_vld}, 16'd0);
        check("mrst_busy", {15'd0, bus.busy}, 16'd0);
        check("mrst_op", {8'd0, bus.opcode}, 16'h00);
        send_byte(8'hA5, v, bz);
        send_byte(8'h66, v, bz);
        send_byte(8'h77, v, bz);
        check("f5_vld", {15'd0, bus.cmd_vld}, 16'd1);
        check("f5_op", {8'd0, bus.opcode}, 16'h66);
        check("f5_data", {8'd0, bus.data}, 16'h77);
        ack_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_seq.md
Name: uart_cmd_seq

Overview:
- Command sequencer between the UART receiver byte interface (rdy/cmd/clr_rdy) and the robot command decoder.
- Consumes received bytes with a clr_rdy handshake and frames them as SYNC, OPCODE, DATA.
- Presents each complete frame to the downstream decoder with a valid/ack handshake.
- Drops malformed and stalled frames, reporting each drop with an error pulse.

Parameters:
SYNC_BYTE, 8'hA5, required value of frame byte 0
TIMEOUT, 16'd52083, max clk cycles allowed between consecutive bytes of one frame (two byte-times at 19200 baud, 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
rx_rdy  in  1  byte available from receiver; stays high until cleared
rx_byte  in  8  received byte, valid while rx_rdy=1
clr_rdy  out  1  one-cycle pulse acknowledging the byte to the receiver
cmd_vld  out  1  frame available; held until accepted
opcode  out  8  frame byte 1
data  out  8  frame byte 2
cmd_ack  in  1  downstream accepts frame
frm_err  out  1  one-cycle pulse: frame dropped
busy  out  1  high in any state other than IDLE

Behaviour:
- All state and outputs are registered; only logic on the clk rising edge.
- Reset (rst_n=0 at a clk edge) values: state=IDLE, clr_rdy=0, cmd_vld=0, opcode=0, data=0, frm_err=0, timeout counter=0.
  - Reset mid-frame or while cmd_vld=1 discards everything.
  - Reset has priority over all other events.
- take = rx_rdy & ~clr_rdy.
  - Guards against double capture, because the receiver drops rdy one cycle after clr_rdy.
  - On take, clr_rdy=1 in the next cycle, for exactly one cycle.
- States:
  - IDLE:
    - take with rx_byte==SYNC_BYTE -> GET_OP.
    - take with any other byte -> stay in IDLE, byte discarded. No frm_err, so line noise between frames is silent.
  - GET_OP:
    - take -> opcode<=rx_byte, go to GET_DATA.
  - GET_DATA:
    - take -> data<=rx_byte, cmd_vld<=1, go to HOLD.
  - HOLD:
    - cmd_vld=1, opcode and data stable.
    - No take: clr_rdy stays 0 and incoming bytes are left pending in the receiver.
    - cmd_ack=1 -> cmd_vld<=0 next cycle, go to IDLE.
    - A byte pending at that point is taken from IDLE one cycle later.
- Latency: frm byte 2 take edge -> cmd_vld high next cycle. cmd_ack edge -> cmd_vld low next cycle.
- cmd_ack outside HOLD is ignored.
- Timeout counter (16 bit):
  - Cleared on every take and in IDLE/HOLD.
  - Increments each cycle in GET_OP/GET_DATA without take.
  - When it reaches TIMEOUT-1 without take: frm_err=1 for one cycle, go to IDLE, counter cleared.
  - If take and the timeout compare occur in the same cycle, take wins and there is no error.
- An opcode byte equal to SYNC_BYTE is legal data. There is no resync mid-frame.
- frm_err and clr_rdy never occur on the same rising edge, because error and take are exclusive.
- busy is high in GET_OP, GET_DATA and HOLD.

Test Plan:
- Frame A5,12,34 with cmd_ack tied 0 -> three clr_rdy pulses, one per byte, each 1 cycle wide; cmd_vld=1 one cycle after the third take; opcode=12, data=34; held for 100 cycles. Then cmd_ack=1 for 1 cycle -> cmd_vld=0 next cycle, state IDLE.
- Bytes 00,FF then A5,01,02 -> first two bytes each consumed with a clr_rdy pulse, no frm_err, no cmd_vld; then frame opcode=01, data=02 delivered.
- A5,07 then silence -> frm_err pulse exactly TIMEOUT cycles after the 07 take (TIMEOUT overridden to 16'd20 for sim); busy=0 after; next frame A5,03,04 delivered correctly.
- rx_rdy held high continuously for a single byte: clr_rdy asserted once only, not twice, verifying the take guard.
- A new byte arrives during HOLD (frame A5,10,20 pending ack, then byte A5): no clr_rdy while cmd_vld=1; after cmd_ack the pending A5 is taken as a new SYNC, busy=1.
- rst_n=0 for one cycle after A5,55 (mid-frame) -> cmd_vld=0, busy=0, opcode=0; subsequent A5,66,77 yields opcode=66, data=77.
